// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: 1-bit PDM to 16-bit signed PCM, 4th-order CIC, decimate by DECIM.
// Optional macro PDM_DC_BLOCK_EN adds a first-order DC-blocking high-pass after
// saturation, one extra cycle of latency.
module pdm_cic_decimator #(
  parameter int DECIM = 32,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pdm_in,
  output logic [OUT_W-1:0] pcm_out,
  output logic             audio_valid
);
  localparam int L  = $clog2(DECIM);
  localparam int W  = 2 + 4 * L;
  localparam int SH = W - 1 - OUT_W;
  localparam int N  = 4;
`ifdef PDM_DC_BLOCK_EN
  localparam int STAGES = 1;
`else
  localparam int STAGES = 0;
`endif

  logic                pdm_q;
  logic [W-1:0]        x_in;
  logic [N-1:0][W-1:0] integ_q, integ_d;
  logic [N-1:0][W-1:0] dly_q;
  logic [N:0][W-1:0]   cmb;
  logic [L-1:0]        cnt_q;
  logic [2:0]          warm_q, warm_d;
  logic                strobe, emit;
  logic signed [W-1:0] shifted;
  logic [OUT_W-1:0]    sat, pcm_q;
  logic [STAGES:0]     vld_pipe_q;

  // Bit 1 -> +1, bit 0 -> -1, sign-extended to the internal width.
  assign x_in   = pdm_q ? {{(W-1){1'b0}}, 1'b1} : {W{1'b1}};
  assign strobe = (cnt_q == L'(DECIM - 1));
  assign emit   = strobe && (warm_q == 3'd4);

  // Integrator cascade; modular arithmetic, wrap-around is expected.
  always_comb begin
    integ_d    = integ_q;
    integ_d[0] = integ_q[0] + x_in;
    for (int i = 1; i < N; i++) integ_d[i] = integ_q[i] + integ_q[i-1];
  end

  // Comb cascade, differential delay 1, fed from the last integrator register.
  always_comb begin
    cmb    = '0;
    cmb[0] = integ_q[N-1];
    for (int i = 0; i < N; i++) cmb[i+1] = cmb[i] - dly_q[i];
  end

  assign shifted = $signed(cmb[N]) >>> SH;

  // Clip the scaled comb output to the signed OUT_W range.
  always_comb begin
    sat = shifted[OUT_W-1:0];
    if (shifted[W-1:OUT_W-1] != '0 && shifted[W-1:OUT_W-1] != '1)
      sat = shifted[W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end

  // Count strobes until the comb transient has flushed, then hold at 4.
  always_comb begin
    warm_d = warm_q;
    if (strobe && warm_q != 3'd4) warm_d = warm_q + 3'd1;
  end

  // Per-cycle state: input flop, integrators, decimation counter, warm-up.
  always_ff @(posedge clk) begin
    if (reset) begin
      pdm_q   <= 1'b0;
      integ_q <= '0;
      cnt_q   <= '0;
      warm_q  <= '0;
    end else begin
      pdm_q   <= pdm_in;
      integ_q <= integ_d;
      cnt_q   <= cnt_q + L'(1);
      warm_q  <= warm_d;
    end
  end

  // Comb delay registers and CIC output register load on the strobe only.
  always_ff @(posedge clk) begin
    if (reset) begin
      dly_q <= '0;
      pcm_q <= '0;
    end else begin
      if (strobe) dly_q <= cmb[N-1:0];
      if (emit)   pcm_q <= sat;
    end
  end

  // Valid shift register; one stage per registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= emit;
      for (int i = 1; i <= STAGES; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  assign audio_valid = vld_pipe_q[STAGES];

`ifdef PDM_DC_BLOCK_EN
  logic signed [OUT_W+1:0] x_ext, xp_ext, yp_ext, dc_sum;
  logic [OUT_W-1:0]        xp_q, yp_q, dc_q, dc_sat;

  assign x_ext  = {{2{pcm_q[OUT_W-1]}}, pcm_q};
  assign xp_ext = {{2{xp_q[OUT_W-1]}}, xp_q};
  assign yp_ext = {{2{yp_q[OUT_W-1]}}, yp_q};

  // y = x - x_prev + y_prev - (y_prev >>> 8), 18-bit sum clipped to OUT_W.
  always_comb begin
    dc_sum = x_ext - xp_ext + yp_ext - (yp_ext >>> 8);
    dc_sat = dc_sum[OUT_W-1:0];
    if (dc_sum[OUT_W+1:OUT_W-1] != 3'b000 && dc_sum[OUT_W+1:OUT_W-1] != 3'b111)
      dc_sat = dc_sum[OUT_W+1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end

  // Filter history advances only on emitted CIC samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      xp_q <= '0;
      yp_q <= '0;
      dc_q <= '0;
    end else if (vld_pipe_q[0]) begin
      xp_q <= pcm_q;
      yp_q <= dc_sat;
      dc_q <= dc_sat;
    end
  end

  assign pcm_out = dc_q;
`else
  assign pcm_out = pcm_q;
`endif

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed bench for pdm_cic_decimator (DECIM=32). Build with PDM_DC_BLOCK_EN
// to exercise the DC-blocking variant instead of the plain CIC scenarios.
module tb_pdm_cic_decimator;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pdm_in = 1'b0;
  logic [15:0] pcm_out;
  logic        audio_valid;
  int          n_vec = 0;
  int          n_bad = 0;

  pdm_cic_decimator #(.DECIM(32), .OUT_W(16)) dut (
    .clk(clk), .reset(reset), .pdm_in(pdm_in),
    .pcm_out(pcm_out), .audio_valid(audio_valid)
  );

  always #5 clk = ~clk;

  // Stimulus patterns: 0 all ones, 1 all zeros, 2 alternating, 3 1,1,1,0.
  function automatic logic pat(input int mode, input int n);
    case (mode)
      0: return 1'b1;
      1: return 1'b0;
      2: return (n % 2 == 0);
      default: return (n % 4 != 3);
    endcase
  endfunction

  // Hold reset over a few edges; release at a negedge so the next posedge is cycle 0.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pdm_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    pdm_in = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (pcm_out !== 16'h0000) begin
      n_bad++; $display("FAIL reset_pcm: got %h want 0000", pcm_out);
    end
    n_vec++;
    if (audio_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b want 0", audio_valid);
    end
    reset = 1'b0;
  endtask

`ifndef PDM_DC_BLOCK_EN
  task automatic test_levels();
    logic [15:0] exp_tab [4];
    logic [15:0] held;
    logic        exp_v;
    exp_tab = '{16'h7FFF, 16'h8000, 16'h0000, 16'h4000};
    for (int m = 0; m < 4; m++) begin
      do_reset();
      held = 16'h0000;
      for (int n = 0; n < 300; n++) begin
        pdm_in = pat(m, n);
        @(negedge clk);
        exp_v = (n >= 159) && ((n - 159) % 32 == 0);
        if (exp_v) held = exp_tab[m];
        n_vec++;
        if (audio_valid !== exp_v) begin
          n_bad++; $display("FAIL levels_valid m=%0d n=%0d: got %b want %b", m, n, audio_valid, exp_v);
        end
        n_vec++;
        if (pcm_out !== held) begin
          n_bad++; $display("FAIL levels_pcm m=%0d n=%0d: got %h want %h", m, n, pcm_out, held);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] held;
    logic        exp_v;
    int          t;
    do_reset();
    held = 16'h0000;
    for (int n = 0; n < 560; n++) begin
      pdm_in = pat(3, n);
      reset = (n == 300);
      @(negedge clk);
      if (n == 300) begin
        exp_v = 1'b0;
        held = 16'h0000;
      end else begin
        t = (n < 300) ? n : n - 301;
        exp_v = (t >= 159) && ((t - 159) % 32 == 0);
        if (exp_v) held = 16'h4000;
      end
      n_vec++;
      if (audio_valid !== exp_v) begin
        n_bad++; $display("FAIL midrst_valid n=%0d: got %b want %b", n, audio_valid, exp_v);
      end
      n_vec++;
      if (pcm_out !== held) begin
        n_bad++; $display("FAIL midrst_pcm n=%0d: got %h want %h", n, pcm_out, held);
      end
    end
    reset = 1'b0;
  endtask
`else
  task automatic test_dc_block();
    logic [15:0] exp_tab [5];
    logic [15:0] held;
    logic        exp_v;
    int          k;
    exp_tab = '{16'h7FFF, 16'h7F80, 16'h7F01, 16'h7E82, 16'h7E04};
    do_reset();
    held = 16'h0000;
    k = 0;
    for (int n = 0; n < 300; n++) begin
      pdm_in = 1'b1;
      @(negedge clk);
      exp_v = (n >= 160) && ((n - 160) % 32 == 0);
      if (exp_v && k < 5) begin
        held = exp_tab[k];
        k++;
      end
      n_vec++;
      if (audio_valid !== exp_v) begin
        n_bad++; $display("FAIL dc_valid n=%0d: got %b want %b", n, audio_valid, exp_v);
      end
      n_vec++;
      if (pcm_out !== held) begin
        n_bad++; $display("FAIL dc_pcm n=%0d: got %h want %h", n, pcm_out, held);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef PDM_DC_BLOCK_EN
    test_dc_block();
`else
    test_levels();
    test_mid_reset();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pdm_cic_decimator.md
# pdm_cic_decimator

- Converts the 1-bit PDM stream from the karaoke microphone into 16-bit signed PCM samples.
- Uses a 4th-order CIC decimator (decimation 32 by default), so 1.536 MHz in gives 48 kHz out.
- Sits directly upstream of the SPI output stage and drives its `pcm_out` / `audio_valid` inputs in the `clk` domain.
- The microphone clock is the same 1.536 MHz `clk`.

## Interface

Parameters:
- `DECIM`, default 32: decimation ratio; legal values are 16, 32, 64 (power of two).
- `OUT_W`, default 16: PCM output width. Fixed at 16; exposed for width derivations only.

Ports:
- `clk`  in  1  1.536 MHz system clock; also the PDM bit clock. One clock; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `pdm_in`  in  1  PDM data from the microphone, sampled on posedge `clk`.
- `pcm_out`  out  16  signed PCM sample; held between strobes.
- `audio_valid`  out  1  one-cycle pulse when `pcm_out` carries a new sample.

## Operation

Derived widths:
- L = log2(DECIM).
- Internal width W = 2 + 4·L (22 for DECIM=32).
- SH = W − 1 − OUT_W (5 for DECIM=32).

Datapath:
- **Input flop:** `pdm_in` is registered once, then mapped 1 → +1 and 0 → −1, sign-extended to W bits.
- **Integrators:** 4 cascaded W-bit accumulators, updated every cycle.
  - Two's-complement wrap-around is required and intentional; no saturation here.
- **Decimation counter:** 0..DECIM−1, increments every cycle. The strobe fires when count == DECIM−1, after which the counter wraps to 0.
- **Combs:** 4 cascaded W-bit differentiators, differential delay 1, evaluated on the strobe only.
  - Input is the 4th integrator register.
  - Each comb's delay register loads that stage's input on the strobe.
  - Comb arithmetic is modular W-bit.
- **Scaling:** the comb output is arithmetic-shifted right by SH, then saturated to [−32768, +32767].
  - Full-scale +2^(4L) → +32768 → clipped to 16'h7FFF.
  - Full-scale −2^(4L) → 16'h8000.
- **Warm-up:** a 3-bit counter suppresses `audio_valid` for the first 4 strobes after reset, while comb transients settle.
  - `pcm_out` is not updated during warm-up.
  - From the 5th strobe on, every strobe emits a sample.
- **Output register:** `pcm_out` and `audio_valid` are registered. `audio_valid` is high for exactly one cycle per emitted sample.

Reset (synchronous):
- All integrators, combs, counters and warm-up state are cleared.
- `pcm_out` = 16'h0000, `audio_valid` = 0.
- Asserting reset mid-operation discards the partial frame and restarts warm-up; no sample is emitted from pre-reset state.

## Timing

- Reset deasserted before posedge 0; the counter is 0 at posedge 0.
- Strobe k (k ≥ 1) occurs on posedge k·DECIM − 1.
- `audio_valid` rises on the cycle after strobe k, for k ≥ 5.
  - With defaults, the first pulse is visible after posedge 159 and lasts until posedge 160.
  - Pulses then repeat every DECIM cycles.
- Latency from a `pdm_in` bit to its first influence on the integrators is 2 cycles (input flop, then integrator 1).
- No backpressure: the consumer must accept every pulse. The downstream SPI stage latches on `audio_valid`.
- `pcm_out` is stable for DECIM−1 cycles after each pulse.

## Configuration

Macro `PDM_DC_BLOCK_EN`.

When defined, a first-order DC-blocking high-pass stage is inserted after saturation:
- Recurrence: y = x − x_prev + y_prev − (y_prev >>> 8).
- The sum is computed in 18 bits, then saturated to 16 bits.
- `x_prev` and `y_prev` are reset to 0 and update only on emitted samples (post-warm-up).
- Adds one cycle: `audio_valid` rises one cycle later than with the macro undefined.

When undefined:
- The stage is absent.
- `pcm_out` is the saturated CIC output with the timing above.

## Test plan

1. Reset, then `pdm_in` held 1, macro off:
   - no `audio_valid` before posedge 159;
   - then pulses every 32 cycles;
   - all emitted samples are 16'h7FFF.
2. `pdm_in` held 0: all emitted samples are 16'h8000 (−32768), with the same pulse timing.
3. `pdm_in` alternating 1,0,1,0…: all emitted samples are 16'h0000.
4. `pdm_in` repeating 1,1,1,0 (75% density): all emitted samples are 16'h4000 (+16384).
5. Steady 75% stream, reset asserted for one cycle mid-frame at posedge 300:
   - `audio_valid` is 0 and `pcm_out` is 16'h0000 the next cycle;
   - no pulse appears until 160 cycles after reset release;
   - then samples are 16'h4000.
6. Macro on, `pdm_in` held 1:
   - first pulse is one cycle later than scenario 1;
   - first sample is 16'h7FFF, second is 16'h7F80;
   - subsequent samples decay monotonically toward 0.
